apb4_master_nslv: RTL and testbench

APB4_MASTER_NSLV -- requirements
Module: apb4_master_nslv

---
 rtl/apb4_master_nslv.sv | 177 +++++++++++++++++
 tb/tb_apb4_master_nslv.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_master_nslv.sv
// APB4 master bridging a simple request/response port onto NUM_SLAVES APB4 slaves.
// Each slave has its own PSEL line. The slave is picked from an address bit field.
// The access phase is bounded by a timeout.

package apb4_master_nslv_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;
endpackage

module apb4_master_nslv
    import apb4_master_nslv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SLV_LSB    = 12,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           transfer,
    input  logic                           SWRITE,
    input  logic [ADDR_WIDTH-1:0]          SADDR,
    input  logic [DATA_WIDTH-1:0]          SWDATA,
    input  logic [DATA_WIDTH/8-1:0]        SSTRB,
    input  logic [2:0]                     SPROT,
    output logic                           sready,
    output logic [DATA_WIDTH-1:0]          SRDATA,
    output logic                           SDONE,
    output logic                           SERR,
    output logic [NUM_SLAVES-1:0]          PSEL,
    output logic                           PENABLE,
    output logic                           PWRITE,
    output logic [ADDR_WIDTH-1:0]          PADDR,
    output logic [DATA_WIDTH-1:0]          PWDATA,
    output logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [2:0]                     PPROT,
    input  logic [NUM_SLAVES-1:0]          PREADY,
    input  logic [NUM_SLAVES-1:0]          PSLVERR,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    output state_e                         cs
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    logic [IDX_W-1:0]      raw_idx;
    logic [IDX_W-1:0]      dec_idx;
    logic                  bad_idx;
    logic [NUM_SLAVES-1:0] dec_onehot;
    logic                  accept;

    logic [IDX_W-1:0]      idx_q;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  bad_pend;

    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    // With a single slave there is no index field; everything goes to slave 0.
    assign raw_idx    = SADDR[SLV_LSB +: IDX_W];
    assign dec_idx    = (NUM_SLAVES > 1) ? raw_idx : '0;
    assign bad_idx    = (32'(dec_idx) >= NUM_SLAVES);
    assign dec_onehot = NUM_SLAVES'(1) << dec_idx;

    // A new request may be taken while idle or on the completing access cycle.
    assign sready = (cs == IDLE) || ((cs == ACCESS) && sel_ready);
    assign accept = transfer && sready;

    // Response mux of the slave latched for the current transfer; others are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Transfer FSM with registered APB and response outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cs       <= IDLE;
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            PSTRB    <= '0;
            PPROT    <= '0;
            SRDATA   <= '0;
            SDONE    <= 1'b0;
            SERR     <= 1'b0;
            idx_q    <= '0;
            wait_cnt <= '0;
            bad_pend <= 1'b0;
        end else begin
            SDONE <= 1'b0;
            SERR  <= 1'b0;

            // Deferred error for a bad-index request taken on a completing cycle.
            if (bad_pend) begin
                SDONE    <= 1'b1;
                SERR     <= 1'b1;
                bad_pend <= 1'b0;
            end

            if ((cs == ACCESS) && sel_ready) begin
                SDONE <= 1'b1;
                SERR  <= sel_err;
                if (!PWRITE) begin
                    SRDATA <= sel_rdata;
                end
            end

            if (accept) begin
                PENABLE <= 1'b0;
                if (bad_idx) begin
                    cs   <= IDLE;
                    PSEL <= '0;
                    // The response slot may already hold a completion pulse; defer then.
                    if ((cs == ACCESS) || bad_pend) begin
                        bad_pend <= 1'b1;
                    end else begin
                        SDONE <= 1'b1;
                        SERR  <= 1'b1;
                    end
                end else begin
                    cs       <= SETUP;
                    PSEL     <= dec_onehot;
                    PWRITE   <= SWRITE;
                    PADDR    <= SADDR;
                    PWDATA   <= SWRITE ? SWDATA : '0;
                    PSTRB    <= SWRITE ? SSTRB : STRB_W'(0);
                    PPROT    <= SPROT;
                    idx_q    <= dec_idx;
                    wait_cnt <= '0;
                end
            end else begin
                case (cs)
                    SETUP: begin
                        cs      <= ACCESS;
                        PENABLE <= 1'b1;
                    end
                    ACCESS: begin
                        if (sel_ready) begin
                            cs      <= IDLE;
                            PSEL    <= '0;
                            PENABLE <= 1'b0;
                        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                            cs       <= IDLE;
                            PSEL     <= '0;
                            PENABLE  <= 1'b0;
                            SDONE    <= 1'b1;
                            SERR     <= 1'b1;
                            wait_cnt <= CNT_W'(TIMEOUT);
                        end else begin
                            wait_cnt <= CNT_W'(wait_cnt + 1'b1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb4_master_nslv.sv
// Directed bench for apb4_master_nslv: per-cycle vector table plus timeout and reset sequences.

module tb_apb4_master_nslv;
    import apb4_master_nslv_pkg::*;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          transfer;
    logic          SWRITE;
    logic [31:0]   SADDR;
    logic [31:0]   SWDATA;
    logic [3:0]    SSTRB;
    logic [2:0]    SPROT;
    logic          sready;
    logic [31:0]   SRDATA;
    logic          SDONE;
    logic          SERR;
    logic [3:0]    PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [31:0]   PADDR;
    logic [31:0]   PWDATA;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic [3:0]    PREADY;
    logic [3:0]    PSLVERR;
    logic [127:0]  PRDATA;
    state_e        cs;

    int n_vec = 0;
    int n_err = 0;

    apb4_master_nslv #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_SLAVES(4),
        .SLV_LSB   (12),
        .TIMEOUT   (16)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .transfer(transfer),
        .SWRITE  (SWRITE),
        .SADDR   (SADDR),
        .SWDATA  (SWDATA),
        .SSTRB   (SSTRB),
        .SPROT   (SPROT),
        .sready  (sready),
        .SRDATA  (SRDATA),
        .SDONE   (SDONE),
        .SERR    (SERR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PPROT   (PPROT),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .PRDATA  (PRDATA),
        .cs      (cs)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        tr;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  rdy;
        logic [3:0]  err;
        state_e      e_cs;
        logic [3:0]  e_psel;
        logic        e_pen;
        logic        e_srdy;
        logic        e_done;
        logic        e_serr;
        logic [31:0] e_srdata;
        logic        bus;
        logic        e_pwr;
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic [3:0]  e_pstrb;
    } vec_t;

    localparam int NV = 25;
    vec_t v[NV];

    function automatic vec_t mk(
        input logic tr, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
        input logic [3:0] strb, input logic [3:0] rdy, input logic [3:0] err,
        input state_e e_cs, input logic [3:0] e_psel, input logic e_pen, input logic e_srdy,
        input logic e_done, input logic e_serr, input logic [31:0] e_srdata,
        input logic bus, input logic e_pwr, input logic [31:0] e_paddr,
        input logic [31:0] e_pwdata, input logic [3:0] e_pstrb);
        vec_t r;
        r.tr = tr; r.wr = wr; r.addr = addr; r.wdata = wdata; r.strb = strb;
        r.rdy = rdy; r.err = err; r.e_cs = e_cs; r.e_psel = e_psel; r.e_pen = e_pen;
        r.e_srdy = e_srdy; r.e_done = e_done; r.e_serr = e_serr; r.e_srdata = e_srdata;
        r.bus = bus; r.e_pwr = e_pwr; r.e_paddr = e_paddr; r.e_pwdata = e_pwdata;
        r.e_pstrb = e_pstrb;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        transfer = r.tr;
        SWRITE   = r.wr;
        SADDR    = r.addr;
        SWDATA   = r.wdata;
        SSTRB    = r.strb;
        PREADY   = r.rdy;
        PSLVERR  = r.err;
    endtask

    task automatic check_row(input int i);
        n_vec++;
        chk($sformatf("r%0d_cs", i),      32'(cs),      32'(v[i].e_cs));
        chk($sformatf("r%0d_psel", i),    32'(PSEL),    32'(v[i].e_psel));
        chk($sformatf("r%0d_penable", i), 32'(PENABLE), 32'(v[i].e_pen));
        chk($sformatf("r%0d_sready", i),  32'(sready),  32'(v[i].e_srdy));
        chk($sformatf("r%0d_sdone", i),   32'(SDONE),   32'(v[i].e_done));
        chk($sformatf("r%0d_serr", i),    32'(SERR),    32'(v[i].e_serr));
        chk($sformatf("r%0d_srdata", i),  SRDATA,       v[i].e_srdata);
        if (v[i].bus) begin
            chk($sformatf("r%0d_pwrite", i), 32'(PWRITE), 32'(v[i].e_pwr));
            chk($sformatf("r%0d_paddr", i),  PADDR,       v[i].e_paddr);
            chk($sformatf("r%0d_pwdata", i), PWDATA,      v[i].e_pwdata);
            chk($sformatf("r%0d_pstrb", i),  32'(PSTRB),  32'(v[i].e_pstrb));
            chk($sformatf("r%0d_pprot", i),  32'(PPROT),  32'h2);
        end
    endtask

    // Hard stop in case something wedges the stimulus process.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_acc;
        bit  done;

        // Zero wait write to slave 2, then a 3-wait read from slave 1.
        v[0]  = mk(1,1,32'h0000_2010,32'hDEADBEEF,4'hF,4'b0000,4'b0000, IDLE,  4'b0000,0,1,0,0,32'h0,        0,0,32'h0,32'h0,4'h0);
        v[1]  = mk(0,1,32'h0000_2010,32'hDEADBEEF,4'hF,4'b0100,4'b0000, SETUP, 4'b0100,0,0,0,0,32'h0,        1,1,32'h0000_2010,32'hDEADBEEF,4'hF);
        v[2]  = mk(0,1,32'h0000_2010,32'hDEADBEEF,4'hF,4'b0100,4'b0000, ACCESS,4'b0100,1,1,0,0,32'h0,        1,1,32'h0000_2010,32'hDEADBEEF,4'hF);
        v[3]  = mk(0,1,32'h0000_2010,32'hDEADBEEF,4'hF,4'b0000,4'b0000, IDLE,  4'b0000,0,1,1,0,32'h0,        0,0,32'h0,32'h0,4'h0);
        v[4]  = mk(1,0,32'h0000_1004,32'hFFFFFFFF,4'hF,4'b0000,4'b0000, IDLE,  4'b0000,0,1,0,0,32'h0,        0,0,32'h0,32'h0,4'h0);
        v[5]  = mk(0,0,32'h0000_1004,32'hFFFFFFFF,4'hF,4'b1101,4'b0000, SETUP, 4'b0010,0,0,0,0,32'h0,        1,0,32'h0000_1004,32'h0,4'h0);
        v[6]  = mk(0,0,32'h0000_1004,32'hFFFFFFFF,4'hF,4'b1101,4'b0000, ACCESS,4'b0010,1,0,0,0,32'h0,        1,0,32'h0000_1004,32'h0,4'h0);
        v[7]  = mk(0,0,32'h0000_1004,32'hFFFFFFFF,4'hF,4'b1101,4'b0000, ACCESS,4'b0010,1,0,0,0,32'h0,        1,0,32'h0000_1004,32'h0,4'h0);
        v[8]  = mk(0,0,32'h0000_1004,32'hFFFFFFFF,4'hF,4'b1101,4'b0000, ACCESS,4'b0010,1,0,0,0,32'h0,        1,0,32'h0000_1004,32'h0,4'h0);
        v[9]  = mk(0,0,32'h0000_1004,32'hFFFFFFFF,4'hF,4'b0010,4'b0000, ACCESS,4'b0010,1,1,0,0,32'h0,        1,0,32'h0000_1004,32'h0,4'h0);
        v[10] = mk(0,0,32'h0000_1004,32'hFFFFFFFF,4'hF,4'b0000,4'b0000, IDLE,  4'b0000,0,1,1,0,32'h12345678, 0,0,32'h0,32'h0,4'h0);
        // Back-to-back writes to slaves 0 and 3 with transfer held high.
        v[11] = mk(1,1,32'h0000_0020,32'h11111111,4'h3,4'b0000,4'b0000, IDLE,  4'b0000,0,1,0,0,32'h12345678, 0,0,32'h0,32'h0,4'h0);
        v[12] = mk(1,1,32'h0000_3030,32'h22222222,4'hC,4'b0001,4'b0000, SETUP, 4'b0001,0,0,0,0,32'h12345678, 1,1,32'h0000_0020,32'h11111111,4'h3);
        v[13] = mk(1,1,32'h0000_3030,32'h22222222,4'hC,4'b0001,4'b0000, ACCESS,4'b0001,1,1,0,0,32'h12345678, 1,1,32'h0000_0020,32'h11111111,4'h3);
        v[14] = mk(0,1,32'h0000_3030,32'h22222222,4'hC,4'b1000,4'b0000, SETUP, 4'b1000,0,0,1,0,32'h12345678, 1,1,32'h0000_3030,32'h22222222,4'hC);
        v[15] = mk(0,1,32'h0000_3030,32'h22222222,4'hC,4'b1000,4'b0000, ACCESS,4'b1000,1,1,0,0,32'h12345678, 1,1,32'h0000_3030,32'h22222222,4'hC);
        v[16] = mk(0,1,32'h0000_3030,32'h22222222,4'hC,4'b0000,4'b0000, IDLE,  4'b0000,0,1,1,0,32'h12345678, 0,0,32'h0,32'h0,4'h0);
        // Slave error on a read from slave 2, then a clean read from slave 3.
        v[17] = mk(1,0,32'h0000_2000,32'h0,4'hF,4'b0000,4'b0000,        IDLE,  4'b0000,0,1,0,0,32'h12345678, 0,0,32'h0,32'h0,4'h0);
        v[18] = mk(0,0,32'h0000_2000,32'h0,4'hF,4'b0100,4'b1011,        SETUP, 4'b0100,0,0,0,0,32'h12345678, 1,0,32'h0000_2000,32'h0,4'h0);
        v[19] = mk(0,0,32'h0000_2000,32'h0,4'hF,4'b0100,4'b0100,        ACCESS,4'b0100,1,1,0,0,32'h12345678, 1,0,32'h0000_2000,32'h0,4'h0);
        v[20] = mk(0,0,32'h0000_2000,32'h0,4'hF,4'b0000,4'b0000,        IDLE,  4'b0000,0,1,1,1,32'hC2C2C2C2, 0,0,32'h0,32'h0,4'h0);
        v[21] = mk(1,0,32'h0000_3000,32'h0,4'hF,4'b0000,4'b0000,        IDLE,  4'b0000,0,1,0,0,32'hC2C2C2C2, 0,0,32'h0,32'h0,4'h0);
        v[22] = mk(0,0,32'h0000_3000,32'h0,4'hF,4'b1000,4'b0111,        SETUP, 4'b1000,0,0,0,0,32'hC2C2C2C2, 1,0,32'h0000_3000,32'h0,4'h0);
        v[23] = mk(0,0,32'h0000_3000,32'h0,4'hF,4'b1000,4'b0111,        ACCESS,4'b1000,1,1,0,0,32'hC2C2C2C2, 1,0,32'h0000_3000,32'h0,4'h0);
        v[24] = mk(0,0,32'h0000_3000,32'h0,4'hF,4'b0000,4'b0000,        IDLE,  4'b0000,0,1,1,0,32'hD3D3D3D3, 0,0,32'h0,32'h0,4'h0);

        PRDATA   = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'h12345678, 32'hA0A0A0A0};
        PRESETn  = 1'b0;
        transfer = 1'b0;
        SWRITE   = 1'b0;
        SADDR    = '0;
        SWDATA   = '0;
        SSTRB    = '0;
        SPROT    = 3'b010;
        PREADY   = '0;
        PSLVERR  = '0;

        // Reset state.
        repeat (2) @(negedge PCLK);
        #1;
        n_vec++;
        chk("rst_cs",     32'(cs),      32'(IDLE));
        chk("rst_psel",   32'(PSEL),    32'h0);
        chk("rst_pen",    32'(PENABLE), 32'h0);
        chk("rst_sready", 32'(sready),  32'h1);
        chk("rst_sdone",  32'(SDONE),   32'h0);
        chk("rst_srdata", SRDATA,       32'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Cycle-by-cycle vector table.
        for (int i = 0; i < NV; i++) begin
            @(negedge PCLK);
            drive(v[i]);
            #1;
            check_row(i);
        end

        // Timeout: slave 1 never ready, the others are ready but must be ignored.
        @(negedge PCLK);
        transfer = 1'b1; SWRITE = 1'b1; SADDR = 32'h0000_1000; SWDATA = 32'h55AA55AA;
        SSTRB = 4'hF; PREADY = 4'b1101; PSLVERR = 4'b0000;
        @(negedge PCLK);
        transfer = 1'b0;
        n_acc = 0;
        done  = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (cs == ACCESS) n_acc++;
            else if (cs == IDLE) done = 1'b1;
            if (!done) @(negedge PCLK);
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL to_wait: got no abort within 40 cycles, expected abort after 16");
        end else begin
            chk("to_acc_cycles", 32'(n_acc),   32'd16);
            chk("to_psel",       32'(PSEL),    32'h0);
            chk("to_pen",        32'(PENABLE), 32'h0);
            chk("to_sdone",      32'(SDONE),   32'h1);
            chk("to_serr",       32'(SERR),    32'h1);
            chk("to_srdata",     SRDATA,       32'hD3D3D3D3);
        end
        @(negedge PCLK);
        #1;
        n_vec++;
        chk("to_sdone_drop", 32'(SDONE), 32'h0);

        // Reset during the wait phase of a write to slave 2.
        @(negedge PCLK);
        transfer = 1'b1; SWRITE = 1'b1; SADDR = 32'h0000_2000; SWDATA = 32'hCAFEF00D;
        SSTRB = 4'hF; SPROT = 3'b101; PREADY = 4'b0000;
        @(negedge PCLK);
        transfer = 1'b0;
        repeat (2) @(negedge PCLK);
        #1;
        n_vec++;
        chk("pre_rst_cs",    32'(cs),    32'(ACCESS));
        chk("pre_rst_pprot", 32'(PPROT), 32'h5);
        #1;
        PRESETn = 1'b0;
        #1;
        n_vec++;
        chk("mid_rst_cs",     32'(cs),      32'(IDLE));
        chk("mid_rst_psel",   32'(PSEL),    32'h0);
        chk("mid_rst_pen",    32'(PENABLE), 32'h0);
        chk("mid_rst_pwrite", 32'(PWRITE),  32'h0);
        chk("mid_rst_paddr",  PADDR,        32'h0);
        chk("mid_rst_pwdata", PWDATA,       32'h0);
        chk("mid_rst_pstrb",  32'(PSTRB),   32'h0);
        chk("mid_rst_pprot",  32'(PPROT),   32'h0);
        chk("mid_rst_srdata", SRDATA,       32'h0);
        chk("mid_rst_sdone",  32'(SDONE),   32'h0);
        chk("mid_rst_serr",   32'(SERR),    32'h0);
        chk("mid_rst_sready", 32'(sready),  32'h1);
        PREADY = 4'b1111;
        repeat (2) begin
            @(negedge PCLK);
            #1;
            n_vec++;
            chk("in_rst_sdone", 32'(SDONE), 32'h0);
        end

        // First request after release is taken on the first rising edge.
        @(negedge PCLK);
        PRESETn = 1'b1; transfer = 1'b1; SWRITE = 1'b0; SADDR = 32'h0000_1000;
        SPROT = 3'b010; PREADY = 4'b0000;
        @(negedge PCLK);
        transfer = 1'b0; PREADY = 4'b0010;
        #1;
        n_vec++;
        chk("post_rst_cs",    32'(cs),    32'(SETUP));
        chk("post_rst_psel",  32'(PSEL),  32'h2);
        chk("post_rst_sdone", 32'(SDONE), 32'h0);
        @(negedge PCLK);
        #1;
        n_vec++;
        chk("post_rst_acc", 32'(cs), 32'(ACCESS));
        @(negedge PCLK);
        PREADY = 4'b0000;
        #1;
        n_vec++;
        chk("post_rst_done",   32'(SDONE), 32'h1);
        chk("post_rst_serr",   32'(SERR),  32'h0);
        chk("post_rst_srdata", SRDATA,     32'h12345678);
        chk("post_rst_idle",   32'(cs),    32'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
